nrzi_unstuff_deserializer: RTL
==============================

// Module: nrzi_unstuff_deserializer
// PURPOSE
//  Receive-path successor to the single-bit NRZI decoder: NRZI decode, bit-unstuff and
//  deserialise the serial stream from the D+/D- receiver into WIDTH-bit words.
//  Sits between the dpdm receiver and the PID/CRC checkers; flags stuff errors and
//  residual (non-word-aligned) bits at end of packet.
// PARAMETERS
//  WIDTH      8  word width, bits assembled LSB-first
//  STUFF_LEN  6  consecutive decoded 1s after which one stuffed 0 is removed
//  IDLE_LEVEL 1  line level (J) preloaded as previous bit at packet start
// PORTS
//  clock         in   1                  system clock, all state on posedge
//  reset         in   1                  synchronous, active-high
//  in_bit        in   1                  raw line bit (J=1, K=0), one per cycle
//  dpdm_sending  in   1                  high while in_bit carries packet bits
//  out_bit       out  1                  decoded, unstuffed data bit
//  bit_valid     out  1                  out_bit is a data bit this cycle
//  word          out  WIDTH              assembled word, bit 0 = first received
//  word_valid    out  1                  one-cycle strobe, word holds WIDTH new bits
//  stuff_err     out  1                  one-cycle pulse: STUFF_LEN+1 decoded 1s
//  done          out  1                  one-cycle pulse, cycle after packet end
//  partial       out  1                  valid with done: residual_cnt != 0
//  residual_cnt  out  $clog2(WIDTH+1)    bits left in word at packet end (valid with done)
// BEHAVIOUR
//  - Reset: all outputs 0, word=0, prev_bit=IDLE_LEVEL, ones_cnt=0, bit_cnt=0, state=DRAIN.
//  - Decode: d = (in_bit == prev_bit); prev_bit <= in_bit each cycle dpdm_sending=1;
//    prev_bit <= IDLE_LEVEL each cycle dpdm_sending=0.
//  - Latency: all outputs registered; bit sampled in cycle N appears in cycle N+1.
//  - States: DRAIN, IDLE, RECV, STUFF, ERROR.
//    DRAIN: ignore input; -> IDLE when dpdm_sending=0 (no done pulse).
//    IDLE: dpdm_sending=1 -> treat sample as data bit as in RECV, go RECV/STUFF.
//    RECV: d=1 -> ones_cnt++, emit; d=0 -> ones_cnt=0, emit;
//          ones_cnt reaching STUFF_LEN -> STUFF.
//    STUFF: d=0 -> drop bit (bit_valid=0), ones_cnt=0, -> RECV;
//           d=1 -> stuff_err=1 next cycle, -> ERROR.
//    ERROR: no bit_valid/word_valid; hold until packet end.
//    Any of RECV/STUFF/ERROR with dpdm_sending=0 -> IDLE, done=1 next cycle.
//  - Deserialise: word <= {out, word[WIDTH-1:1]}, bit_cnt++ per emitted bit;
//    at bit_cnt==WIDTH-1 word_valid=1 in same cycle as final bit_valid, bit_cnt=0.
//  - End: residual_cnt=bit_cnt, partial=(bit_cnt!=0) with done; then bit_cnt=0,
//    ones_cnt=0; word holds last value. In ERROR, partial/residual still reported.
//  - Boundaries: end while in STUFF -> done, no stuff_err. Back-to-back packets need
//    >=1 cycle of dpdm_sending=0. A stuff bit that completes a word is impossible
//    (dropped bits never count). Reset mid-packet -> DRAIN; no output until line idles.
// STRUCTURE
//  - usb_rx_pkg: rx_state_t enum {DRAIN,IDLE,RECV,STUFF,ERROR}; USB_STUFF_LEN=6;
//    LINE_J=1, LINE_K=0.
//  - One sub-module: lsb_deserializer #(WIDTH) (bit, load, clear -> word,
//    word_valid, bit_cnt). NRZI decode and unstuff FSM live in the top module.
// TESTING
//  - SYNC: line 0,1,0,1,0,1,0,0 -> word_valid once, word=8'h80, done, partial=0.
//  - Stuffing: line held 1 for 6 bits then 0 -> six bit_valid 1s, stuffed bit has
//    bit_valid=0, stuff_err=0.
//  - Stuff error: line held 1 for 7 bits -> stuff_err pulse cycle 8; no further
//    bit_valid; done after dpdm_sending drops.
//  - Residual: 11 data bits then dpdm_sending=0 -> one word_valid, done with partial=1,
//    residual_cnt=3.
//  - Reset asserted mid-packet, dpdm_sending stays 1 for 5 cycles -> no bit_valid/done
//    until one idle cycle, next packet decodes normally.
//  - WIDTH=16, STUFF_LEN=4: 4 ones + stuffed 0 + 12 data bits -> word_valid with
//    16 data bits, stuffed bit excluded.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and line constants for the USB receive path.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    RECV,
    STUFF,
    ERROR
  } rx_state_t;

  localparam int   USB_STUFF_LEN = 6;
  localparam logic LINE_J        = 1'b1;
  localparam logic LINE_K        = 1'b0;

endpackage

// File: rtl/lsb_deserializer.sv
// Shifts data bits in LSB-first and strobes word_valid when WIDTH bits are collected.
module lsb_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_bit,
  input  logic                       load,
  input  logic                       clear,
  output logic [WIDTH-1:0]           word,
  output logic                       word_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      word       <= '0;
      word_valid <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        bit_cnt <= '0;
      end else if (load) begin
        // newest bit enters at the top so the first bit ends up in bit 0
        word <= {data_bit, word[WIDTH-1:1]};
        if (bit_cnt == LAST) begin
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/nrzi_unstuff_deserializer.sv
// NRZI decode, bit-unstuff and deserialise the receiver bit stream into words.
module nrzi_unstuff_deserializer
  import usb_rx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   STUFF_LEN  = USB_STUFF_LEN,
  parameter logic IDLE_LEVEL = LINE_J
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_bit,
  input  logic                       dpdm_sending,
  output logic                       out_bit,
  output logic                       bit_valid,
  output logic [WIDTH-1:0]           word,
  output logic                       word_valid,
  output logic                       stuff_err,
  output logic                       done,
  output logic                       partial,
  output logic [$clog2(WIDTH+1)-1:0] residual_cnt
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [OW-1:0] ONES_LAST = OW'(STUFF_LEN - 1);
  localparam logic [OW-1:0] ONES_FULL = OW'(STUFF_LEN);

  rx_state_t     state, state_next;
  logic          prev_bit;
  logic [OW-1:0] ones_cnt, ones_next;
  logic [CW-1:0] bit_cnt;
  logic          d;
  logic          emit;
  logic          err_set;
  logic          end_pkt;

  always_comb begin
    d          = (in_bit == prev_bit);
    state_next = state;
    ones_next  = ones_cnt;
    emit       = 1'b0;
    err_set    = 1'b0;
    end_pkt    = 1'b0;
    case (state)
      DRAIN: begin
        if (!dpdm_sending) state_next = IDLE;
      end
      IDLE, RECV: begin
        if (dpdm_sending) begin
          emit       = 1'b1;
          state_next = RECV;
          if (!d) begin
            ones_next = '0;
          end else if (ones_cnt == ONES_LAST) begin
            ones_next  = ONES_FULL;
            state_next = STUFF;
          end else begin
            ones_next = ones_cnt + OW'(1);
          end
        end else if (state == RECV) begin
          end_pkt = 1'b1;
        end
      end
      STUFF: begin
        if (!dpdm_sending) begin
          end_pkt = 1'b1;
        end else if (!d) begin
          ones_next  = '0;
          state_next = RECV;
        end else begin
          err_set    = 1'b1;
          state_next = ERROR;
        end
      end
      ERROR: begin
        if (!dpdm_sending) end_pkt = 1'b1;
      end
      default: state_next = DRAIN;
    endcase
    if (end_pkt) begin
      state_next = IDLE;
      ones_next  = '0;
    end
  end

  // registered stage: every output reflects the sample taken on the previous edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= DRAIN;
      prev_bit     <= IDLE_LEVEL;
      ones_cnt     <= '0;
      out_bit      <= 1'b0;
      bit_valid    <= 1'b0;
      stuff_err    <= 1'b0;
      done         <= 1'b0;
      partial      <= 1'b0;
      residual_cnt <= '0;
    end else begin
      state        <= state_next;
      ones_cnt     <= ones_next;
      prev_bit     <= dpdm_sending ? in_bit : IDLE_LEVEL;
      out_bit      <= emit & d;
      bit_valid    <= emit;
      stuff_err    <= err_set;
      done         <= end_pkt;
      partial      <= end_pkt && (bit_cnt != '0);
      residual_cnt <= end_pkt ? bit_cnt : '0;
    end
  end

  lsb_deserializer #(
    .WIDTH(WIDTH)
  ) u_deser (
    .clock     (clock),
    .reset     (reset),
    .data_bit  (d),
    .load      (emit),
    .clear     (end_pkt),
    .word      (word),
    .word_valid(word_valid),
    .bit_cnt   (bit_cnt)
  );

endmodule
